// File: rtl/flags_register.sv
// Processor status (P) register for the Core6502 datapath.
// Holds C/Z/I/D/V/N, drives the P image onto the internal bus and sets V on a falling SO pin.
module flags_register #(
    parameter logic RESET_I        = 1'b1,
    parameter int   SO_SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] DB_IN,
    input  logic       IR5,
    input  logic       ACR,
    input  logic       AVR,
    input  logic       n_SO,
    input  logic       B_IN,
    input  logic       P_DB,
    input  logic       IR5_I,
    input  logic       IR5_C,
    input  logic       IR5_D,
    input  logic       Z_V,
    input  logic       ACR_C,
    input  logic       AVR_V,
    input  logic       DBZ_Z,
    input  logic       DB_N,
    input  logic       DB_P,
    input  logic       DB_C,
    input  logic       DB_V,
    output logic [7:0] DB_OUT,
    output logic       DB_OE,
    output logic       C_OUT,
    output logic       Z_OUT,
    output logic       I_OUT,
    output logic       D_OUT,
    output logic       V_OUT,
    output logic       N_OUT
);

    logic c_flag, z_flag, i_flag, d_flag, v_flag, n_flag;

    logic [SO_SYNC_STAGES-1:0] so_sync;
    logic                      so_edge;
    logic [SO_SYNC_STAGES:0]   so_valid;
    logic                      so_fall;

    // so_valid tracks which SO flops hold a real pin sample rather than the reset value,
    // so a pin already held low across reset is not mistaken for a new falling edge.
    assign so_fall = so_valid[SO_SYNC_STAGES] & so_edge & ~so_sync[SO_SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            so_sync  <= '1;
            so_edge  <= 1'b1;
            so_valid <= '0;
        end else begin
            so_sync  <= {so_sync[SO_SYNC_STAGES-2:0], n_SO};
            so_edge  <= so_sync[SO_SYNC_STAGES-1];
            so_valid <= {so_valid[SO_SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            c_flag <= 1'b0;
            z_flag <= 1'b0;
            i_flag <= RESET_I;
            d_flag <= 1'b0;
            v_flag <= 1'b0;
            n_flag <= 1'b0;
        end else begin
            if (DB_C)
                c_flag <= DB_IN[0];
            else if (ACR_C)
                c_flag <= ACR;
            else if (IR5_C)
                c_flag <= IR5;

            if (DB_P)
                z_flag <= DB_IN[1];
            else if (DBZ_Z)
                z_flag <= (DB_IN == 8'h00);

            if (DB_P)
                i_flag <= DB_IN[2];
            else if (IR5_I)
                i_flag <= IR5;

            if (DB_P)
                d_flag <= DB_IN[3];
            else if (IR5_D)
                d_flag <= IR5;

            if (DB_N)
                n_flag <= DB_IN[7];

            // The SO pin outranks every bus/ALU source of V.
            if (so_fall)
                v_flag <= 1'b1;
            else if (DB_V)
                v_flag <= DB_IN[6];
            else if (AVR_V)
                v_flag <= AVR;
            else if (Z_V)
                v_flag <= 1'b0;
        end
    end

    assign DB_OE  = P_DB;
    assign DB_OUT = P_DB ? {n_flag, v_flag, 1'b1, B_IN, d_flag, i_flag, z_flag, c_flag} : 8'hFF;

    assign C_OUT = c_flag;
    assign Z_OUT = z_flag;
    assign I_OUT = i_flag;
    assign D_OUT = d_flag;
    assign V_OUT = v_flag;
    assign N_OUT = n_flag;

endmodule

// File: doc/flags_register.md
Name: flags_register

Overview:
- Processor status (P) register for the Core6502 datapath.
- Consumes the flag-load strobes produced by the flag-control decode stage (P_DB, IR5_I/C/D, Z_V, ACR_C, DBZ_Z, DB_N, DB_P, DB_C, DB_V, plus AVR_V).
- Holds C, Z, I, D, V, N and drives P onto the internal data bus on request.
- Includes the SO pin synchroniser and falling-edge detector that sets V.

Parameters:
- RESET_I, 1, reset value of the I flag.
- SO_SYNC_STAGES, 2, synchroniser flops ahead of the edge-detect flop (legal range 2..3).

Ports:
- CLK  input  1  core clock; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- DB_IN  input  8  internal data bus value.
- IR5  input  1  opcode bit 5, the value for SEx/CLx.
- ACR  input  1  ALU carry out.
- AVR  input  1  ALU overflow out.
- n_SO  input  1  set-overflow pin, active-low, asynchronous.
- B_IN  input  1  B bit value presented on push (1 = PHP/BRK, 0 = IRQ/NMI).
- P_DB, IR5_I, IR5_C, IR5_D, Z_V, ACR_C, AVR_V, DBZ_Z, DB_N, DB_P, DB_C, DB_V  input  1 each  flag-load strobes; active-high, sampled at the clock edge.
- DB_OUT  output  8  P image onto the bus.
- DB_OE  output  1  bus drive enable.
- C_OUT, Z_OUT, I_OUT, D_OUT, V_OUT, N_OUT  output  1 each  registered flags.

Behaviour:
- Reset (RST=1 at edge):
  - C=Z=D=V=N=0; I=RESET_I.
  - All SO sync/edge flops=1 (idle).
  - Strobes are ignored that cycle.
- Update latency: every strobe sampled at edge k; the new flag is visible on *_OUT after edge k. Flags not addressed hold.
- C priority: DB_C -> DB_IN[0]; else ACR_C -> ACR; else IR5_C -> IR5.
- Z priority: DB_P -> DB_IN[1]; else DBZ_Z -> (DB_IN==8'h00).
- I priority: DB_P -> DB_IN[2]; else IR5_I -> IR5.
- D priority: DB_P -> DB_IN[3]; else IR5_D -> IR5.
- N: DB_N -> DB_IN[7].
- V priority:
  - SO edge -> 1.
  - else DB_V -> DB_IN[6].
  - else AVR_V -> AVR.
  - else Z_V -> 0.
- Simultaneous strobes on one flag resolve by the priority above. Strobes on different flags apply independently in the same edge.
- SO path:
  - n_SO passes through SO_SYNC_STAGES flops s[1..n], then edge flop e (e <= s[n]).
  - Falling edge detect: fall = e & ~s[n].
  - V set at the edge where fall=1.
  - With SO_SYNC_STAGES=2, V_OUT=1 after the 3rd edge following the first edge that samples n_SO=0.
  - A low level held indefinitely sets V once. V may then be cleared by Z_V/DB_V and stays clear until n_SO returns high and falls again.
  - A low pulse captured by a single edge is sufficient.
- Bus drive (combinational from registered flags and current P_DB):
  - DB_OE=P_DB.
  - DB_OUT={N,V,1'b1,B_IN,D,I,Z,C} when P_DB=1; else 8'hFF (precharge).
  - P_DB does not alter flags.
  - P_DB and a DB load in the same cycle: DB_OUT shows the old flags, and the flags update at the edge.
- Reset mid-operation: pending SO detection is discarded. A fall detected at the reset edge is lost. No V set until a new falling edge occurs after reset is released.
- Bits 5 and 4 of P are not stored.

Test Plan:
- Reset then idle: RST=1 one edge -> C,Z,D,V,N=0, I=1. With P_DB=1, DB_OUT=8'h34 (B_IN=1) and 8'h24 (B_IN=0).
- PLP load: DB_IN=8'hCF, DB_P=DB_C=DB_N=DB_V=1 for one edge -> N=1,V=1,D=1,I=1,Z=1,C=1. Next cycle with P_DB=1, B_IN=0: DB_OUT=8'hEF.
- Carry priority: DB_C=1, ACR_C=1, IR5_C=1 with DB_IN[0]=0, ACR=1, IR5=1 -> C=0. Dropping DB_C next edge -> C=1 from ACR.
- Zero detect: DBZ_Z=1, DB_IN=8'h00 -> Z=1. Then DB_IN=8'h80 with DBZ_Z, DB_N -> Z=0, N=1.
- SO edge:
  - n_SO 1->0 held low, with V=0 and Z_V=1 asserted on the 3rd edge -> V=1 after 3rd edge (SO beats Z_V).
  - Z_V on the 4th edge -> V=0 and stays 0 while n_SO remains low.
  - Release and re-fall -> V=1 again.
- Reset during SO: n_SO falls, RST=1 on 2nd edge, released after -> V stays 0 while n_SO stays low. A new 1->0 after reset sets V on the 3rd edge.
